// File: rtl/shift_reg_checker_if.sv
// Stimulus/response bus shared by the 4-bit shift register, its drivers and the checker.
// Test modules drive it through master; the checker only observes through slave.
interface shift_reg_checker_if;
  logic       ENB;
  logic       DIR;
  logic       S_IN;
  logic [1:0] MODO;
  logic [3:0] D;
  logic [3:0] Q;
  logic       S_OUT;

  modport master (output ENB, DIR, S_IN, MODO, D, Q, S_OUT);
  modport slave  (input  ENB, DIR, S_IN, MODO, D, Q, S_OUT);
endinterface

// File: rtl/shift_reg_checker.sv
// Cycle-accurate golden model and per-cycle comparator for the 4-bit shift register.
// Optional SRCHK_SOUT_EN: also model and compare the serial output S_OUT.
module shift_reg_checker #(
  parameter logic [7:0] ERR_LIMIT = 8'd16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  shift_reg_checker_if.slave   bus,
  output logic                 MISMATCH,
  output logic                 ERR,
  output logic [7:0]           ERR_CNT,
  output logic [7:0]           CHK_CNT,
  output logic [3:0]           EXP_Q,
  output logic                 SYNCED,
  output logic                 HALTED
);

  localparam logic [1:0] ModeShift = 2'b00;
  localparam logic [1:0] ModeCirc  = 2'b01;
  localparam logic [1:0] ModeLoad  = 2'b10;

  typedef enum logic [1:0] {StUnsync, StTrack, StHalt} state_e;

  state_e     state_q, state_d;
  logic [3:0] exp_q_q, exp_q_d;
  logic       mismatch_q, mismatch_d;
  logic       err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [7:0] chk_cnt_q, chk_cnt_d;
  logic [7:0] err_cnt_inc;
  logic [3:0] base;
  logic       miss;
  logic       load;

  function automatic logic [3:0] next_bits(logic [3:0] b, logic enb, logic dir, logic s_in,
                                           logic [1:0] modo, logic [3:0] d);
    logic [3:0] r;
    r = b;
    if (enb) begin
      unique case (modo)
        ModeShift: r = dir ? {s_in, b[3:1]} : {b[2:0], s_in};
        ModeCirc:  r = dir ? {b[0], b[3:1]} : {b[2:0], b[3]};
        ModeLoad:  r = d;
        default:   r = b;
      endcase
    end
    return r;
  endfunction

`ifdef SRCHK_SOUT_EN
  logic exp_s_q, exp_s_d;
  logic base_s;
`else
  logic unused_sout;
  assign unused_sout = bus.S_OUT;
`endif

  assign load        = bus.ENB && (bus.MODO == ModeLoad);
  assign err_cnt_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    exp_q_d    = exp_q_q;
    mismatch_d = 1'b0;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;
    chk_cnt_d  = chk_cnt_q;
    base       = exp_q_q;
    miss       = 1'b0;
`ifdef SRCHK_SOUT_EN
    exp_s_d    = exp_s_q;
    base_s     = exp_s_q;
`endif
    unique case (state_q)
      StUnsync: begin
        if (load) begin
          exp_q_d = bus.D;
`ifdef SRCHK_SOUT_EN
          exp_s_d = 1'b0;
`endif
          state_d = StTrack;
        end
      end
      StTrack: begin
        miss = (bus.Q != exp_q_q);
`ifdef SRCHK_SOUT_EN
        miss = miss || (bus.S_OUT != exp_s_q);
`endif
        chk_cnt_d = (chk_cnt_q == 8'hFF) ? chk_cnt_q : chk_cnt_q + 8'd1;
        // On a miss, continue from what the DUT actually holds so one fault counts once.
        if (miss) begin
          mismatch_d = 1'b1;
          err_d      = 1'b1;
          err_cnt_d  = err_cnt_inc;
          base       = bus.Q;
`ifdef SRCHK_SOUT_EN
          base_s     = bus.S_OUT;
`endif
        end
        exp_q_d = next_bits(base, bus.ENB, bus.DIR, bus.S_IN, bus.MODO, bus.D);
`ifdef SRCHK_SOUT_EN
        exp_s_d = base_s;
        if (bus.ENB) begin
          if (bus.MODO == ModeShift || bus.MODO == ModeCirc) begin
            exp_s_d = bus.DIR ? base[0] : base[3];
          end else if (bus.MODO == ModeLoad) begin
            exp_s_d = 1'b0;
          end
        end
`endif
        if (miss && (ERR_LIMIT != 8'd0) && (err_cnt_inc == ERR_LIMIT)) begin
          state_d = StHalt;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: state_d = StUnsync;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= StUnsync;
      exp_q_q    <= 4'd0;
      mismatch_q <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= 8'd0;
      chk_cnt_q  <= 8'd0;
`ifdef SRCHK_SOUT_EN
      exp_s_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      exp_q_q    <= exp_q_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      chk_cnt_q  <= chk_cnt_d;
`ifdef SRCHK_SOUT_EN
      exp_s_q    <= exp_s_d;
`endif
    end
  end

  assign MISMATCH = mismatch_q;
  assign ERR      = err_q;
  assign ERR_CNT  = err_cnt_q;
  assign CHK_CNT  = chk_cnt_q;
  assign EXP_Q    = exp_q_q;
  assign SYNCED   = (state_q == StTrack);
  assign HALTED   = (state_q == StHalt);

endmodule
